// File: rtl/seq_shift_add_multiplier_pkg.sv
// Shared constants and FSM state encoding for the sequential shift-add multiplier
// and the ripple-carry adder it drives.
package seq_shift_add_multiplier_pkg;

  localparam int MUL_WIDTH = 8;
  localparam int MUL_CNT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_shift_add_multiplier_adder.sv
// Purely combinational ripple-carry adder: S = A + B with carry-out c8.
// Each bit position is a full adder chained through carry_s.
module seq_shift_add_multiplier_adder
  import seq_shift_add_multiplier_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] s_out,
  output logic             c8_out
);

  logic [WIDTH:0] carry_s;

  assign carry_s[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign s_out[i]     = a_in[i] ^ b_in[i] ^ carry_s[i];
    assign carry_s[i+1] = (a_in[i] & b_in[i]) | (carry_s[i] & (a_in[i] ^ b_in[i]));
  end

  assign c8_out = carry_s[WIDTH];

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Unsigned WIDTHxWIDTH multiplier, one shift-add step per clock, with
// valid/ready handshakes on both the operand and product sides.
module seq_shift_add_multiplier
  import seq_shift_add_multiplier_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH,
  parameter int CNT_W = MUL_CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mq_q, mq_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] add_s;
  logic             c8_s;
  logic [WIDTH:0]   sum_s;

  seq_shift_add_multiplier_adder #(
    .WIDTH (WIDTH)
  ) u_eight_bit_ripple_carry_adder (
    .a_in   (acc_q),
    .b_in   (mcand_q),
    .s_out  (add_s),
    .c8_out (c8_s)
  );

  // Partial-sum selection for the current multiplier bit; carry lands in sum_s[WIDTH].
  always_comb begin
    sum_s = {1'b0, acc_q};
    if (mq_q[0]) begin
      sum_s = {c8_s, add_s};
    end else begin
      sum_s = {1'b0, acc_q};
    end
  end

  // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mq_d    = mq_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          mcand_d = a;
          mq_d    = b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        acc_d = sum_s[WIDTH:1];
        mq_d  = {sum_s[0], mq_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything so no stale product leaks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      mq_q    <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
    end
  end

  // Handshake flags decode straight from the state flop; product is the acc/mq pair.
  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign product   = {acc_q, mq_q};

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Scoreboard bench for seq_shift_add_multiplier: expected products are queued at
// operand issue and popped when the DUT presents out_valid.
module tb_seq_shift_add_multiplier;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic        busy;

  int n_checks;
  int n_fail;
  logic [15:0] sb_q[$];

  seq_shift_add_multiplier dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
    logic [15:0] acc;
    acc = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) acc = acc + ({8'h00, x} << i);
    end
    return acc;
  endfunction

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++;
    if (product !== 16'h0000) begin n_fail++; $display("FAIL reset_product got=%h exp=0000", product); end
  endtask

  // One full transaction; hold_cycles keeps out_ready low in DONE, with an in_valid pulse.
  task automatic run_op(input logic [7:0] xa, input logic [7:0] xb, input int hold_cycles,
                        input logic [15:0] spec_exp, input string name);
    int lat;
    logic [15:0] exp_p;
    logic [15:0] held;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL %s_in_ready got=%b exp=1", name, in_ready); end
    in_valid = 1'b1; a = xa; b = xb;
    sb_q.push_back(ref_mul(xa, xb));
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (lat != 8) begin n_fail++; $display("FAIL %s_latency got=%0d exp=8", name, lat); end
    exp_p = (sb_q.size() > 0) ? sb_q.pop_front() : 16'hxxxx;
    n_checks++;
    if (product !== exp_p || product !== spec_exp) begin
      n_fail++; $display("FAIL %s_product got=%h exp=%h", name, product, spec_exp);
    end
    held = product;
    for (int i = 0; i < hold_cycles; i++) begin
      if (i == 1) begin in_valid = 1'b1; a = 8'h13; b = 8'h77; end
      else begin in_valid = 1'b0; end
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || product !== held || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_hold%0d got ov=%b p=%h ir=%b exp ov=1 p=%h ir=0", name, i, out_valid, product, in_ready, held);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL %s_release got ov=%b ir=%b busy=%b exp 0/1/0", name, out_valid, in_ready, busy);
    end
  endtask

  task automatic test_basic();
    run_op(8'hAA, 8'h54, 0, 16'h37C8, "aa_54");
    run_op(8'h92, 8'h89, 0, 16'h4E22, "carry_92_89");
    run_op(8'hFF, 8'hFF, 0, 16'hFE01, "ff_ff");
    run_op(8'h00, 8'h5A, 0, 16'h0000, "zero_a");
  endtask

  task automatic test_hold();
    run_op(8'h0D, 8'hB3, 5, 16'h0917, "hold");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    in_valid = 1'b1; a = 8'hC7; b = 8'hE9;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || product !== 16'h0000) begin
      n_fail++;
      $display("FAIL midreset got ir=%b ov=%b busy=%b p=%h exp 1/0/0/0000", in_ready, out_valid, busy, product);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'h03, 8'h05, 0, 16'h000F, "after_reset");
  endtask

  task automatic test_back_to_back();
    logic [7:0] ta[6] = '{8'h01, 8'hFF, 8'h80, 8'h5C, 8'hE1, 8'h7F};
    logic [7:0] tb[6] = '{8'hFF, 8'h01, 8'h80, 8'hA3, 8'h3E, 8'hFE};
    int issued;
    int got;
    int cyc;
    int last_out;
    logic [15:0] exp_p;
    issued = 0; got = 0; cyc = 0; last_out = -1;
    out_ready = 1'b1;
    while (got < 6 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (out_valid === 1'b1) begin
        exp_p = (sb_q.size() > 0) ? sb_q.pop_front() : 16'hxxxx;
        n_checks++;
        if (product !== exp_p) begin n_fail++; $display("FAIL b2b_product%0d got=%h exp=%h", got, product, exp_p); end
        if (last_out >= 0) begin
          n_checks++;
          if (cyc - last_out != 10) begin
            n_fail++; $display("FAIL b2b_interval%0d got=%0d exp=10", got, cyc - last_out);
          end
        end
        last_out = cyc;
        got++;
      end
      if (in_ready === 1'b1) begin
        if (issued < 6) begin
          in_valid = 1'b1; a = ta[issued]; b = tb[issued];
          sb_q.push_back(ref_mul(ta[issued], tb[issued]));
          issued++;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    n_checks++;
    if (got != 6) begin n_fail++; $display("FAIL b2b_count got=%0d exp=6", got); end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = 8'h00; b = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_basic();
    test_hold();
    test_reset_mid();
    sb_q.delete();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
